axi_lite_slave_regfile: RTL
===========================

# axi_lite_slave_regfile

AXI4-Lite responder (slave end) backed by a word-addressed register file. It accepts write address, write data and read address transactions from the master side of the AXI4-Lite interface. It applies byte strobes to stored words and returns OKAY or SLVERR responses. It sits at the slave modport and is the target that the existing master/interconnect logic is verified against.

## Interface
- ADDR_WIDTH, 32, width of awaddr/araddr
- DATA_WIDTH, 32, data width; fixed at 32 (byte lanes = 4)
- NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  reset; synchronous, active-high
- awaddr  input  ADDR_WIDTH  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  32  write data
- wstrb  input  4  write byte strobes; bit i enables wdata[8i+7:8i]
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bresp  output  2  write response (2'b00 OKAY, 2'b10 SLVERR)
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  ADDR_WIDTH  read address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rdata  output  32  read data
- rresp  output  2  read response
- rvalid  output  1  read data valid
- rready  input  1  read data ready

## Operation
- Decode: index = addr[2 +: log2(NUM_REGS)]; addr[1:0] ignored; in range iff addr < NUM_REGS*4.
- Write FSM states: WR_IDLE, WR_RESP.
  - In WR_IDLE, AW and W are captured independently into holding registers. awready = WR_IDLE & !aw_held. wready = WR_IDLE & !w_held.
  - AW and W may arrive in either order or in the same cycle.
  - At the edge where both are held (including the edge of the last handshake), the write commits and the FSM moves to WR_RESP with bvalid=1.
  - In-range commit: for each i with wstrb[i]=1, reg[index][8i+7:8i] <= wdata byte i; other bytes are unchanged. wstrb=0 commits nothing and returns OKAY.
  - Out-of-range commit: no register changes; bresp=SLVERR.
  - WR_RESP holds bvalid and bresp stable until bready=1. On that edge the FSM returns to WR_IDLE and the held flags clear.
- Read FSM states: RD_IDLE, RD_DATA.
  - arready = RD_IDLE.
  - On the AR handshake, rdata/rresp are registered from the array, and then RD_DATA asserts rvalid=1.
  - Out of range: rdata=0, rresp=SLVERR.
  - rdata/rresp are held stable until rready=1, then the FSM returns to RD_IDLE.
- Read and write paths are independent and may overlap.
- A read whose AR handshake falls on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (areset=1 at an edge): all registers are 0, both FSMs go idle, held flags clear. bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
- While areset=1: awready, wready and arready are forced to 0.
- First cycle after reset release: awready=wready=arready=1.
- Write latency: bvalid rises the cycle after the later of the AW/W handshakes. With bready held high, the next AW/W is accepted 2 cycles after the previous one (throughput 1 write per 2 cycles).
- Read latency: rvalid rises the cycle after the AR handshake. With rready held high, throughput is 1 read per 2 cycles.
- Backpressure: valid outputs never drop without the matching ready; payload is stable while valid=1 and ready=0.
- Reset mid-transaction: pending AW/W/AR are discarded with no response issued. An uncommitted write has no effect.

## Configuration
- AXI_LITE_SLV_ERR_EN defined: out-of-range accesses return SLVERR (2'b10), as described above.
- AXI_LITE_SLV_ERR_EN undefined: out-of-range accesses return OKAY. Writes are still dropped and reads still return 0. bresp and rresp are constant 2'b00.

## Test plan
- Reset then full-strobe write: write 0xDEADBEEF to 0x04 with wstrb=4'hF (AW and W same cycle). Expect bvalid 1 cycle later with bresp=00. Reading 0x04 returns 0xDEADBEEF with rresp=00, and rvalid 1 cycle after the AR handshake.
- Partial strobe: starting from 0xDEADBEEF at 0x04, write 0x11223344 with wstrb=4'b0101. A read returns 0xDE22BE44.
- Order independence: W first with 0xA5A5A5A5, then AW to 0x08 three cycles later. Expect wready=0 until the AW arrives, and bvalid the cycle after the AW handshake. A read of 0x08 returns 0xA5A5A5A5.
- Out of range with NUM_REGS=16: write to 0x40, then read 0x40. With the macro defined, expect bresp=10, rresp=10 and rdata=0. Without the macro, expect both responses 00. All 16 registers are unchanged.
- Backpressure and overlap: hold bready=0 and rready=0 for 5 cycles with a write and a read outstanding. Expect bvalid, rvalid and their payloads stable, and awready/arready low. A same-edge AR and write commit to 0x0C returns the old value.
- Mid-operation reset: AW accepted, W pending, then areset pulsed for 1 cycle. Expect no bvalid and all registers 0; the next transaction completes normally.

Source files
------------

// File: rtl/axi_lite_slave_regfile_if.sv
// axi_lite_slave_regfile_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// Parameters:
//   ADDR_WIDTH - width of awaddr/araddr
//   DATA_WIDTH - width of wdata/rdata (32 for this register file)
// Modports:
//   master - drives addresses, write data, strobes, valids and response readies
//   slave  - drives address/data readies, responses and read data
interface axi_lite_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// axi_lite_slave_regfile: AXI4-Lite slave backed by a word-addressed register file.
// Ports:
//   aclk   - clock, all logic on the rising edge
//   areset - synchronous active-high reset
//   s_axi  - AXI4-Lite bus, slave modport
// Parameters: ADDR_WIDTH, DATA_WIDTH (32), NUM_REGS (power of two, 2..256).
// Build option: define AXI_LITE_SLV_ERR_EN to answer out-of-range accesses
// with SLVERR; otherwise they answer OKAY (writes dropped, reads return 0).
module axi_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input logic                     aclk,
    input logic                     areset,
    axi_lite_slave_regfile_if.slave s_axi
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI_LITE_SLV_ERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    wr_state_e               wr_state_q, wr_state_d;
    rd_state_e               rd_state_q, rd_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           wstrb_q, wstrb_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]           wr_strb;
    logic                    wr_in_range, rd_in_range;
    logic [IW-1:0]           wr_idx, rd_idx;

    assign s_axi.awready = !areset && wr_state_q == WR_IDLE && !aw_held_q;
    assign s_axi.wready  = !areset && wr_state_q == WR_IDLE && !w_held_q;
    assign s_axi.arready = !areset && rd_state_q == RD_IDLE;
    assign s_axi.bvalid  = wr_state_q == WR_RESP;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rd_state_q == RD_DATA;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;
    assign ar_hs = s_axi.arvalid && s_axi.arready;

    // The commit edge may coincide with the last handshake, so take each
    // half of the write from the bus when it is not already held.
    assign wr_addr = aw_held_q ? awaddr_q : s_axi.awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axi.wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axi.wstrb;
    assign commit  = wr_state_q == WR_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_in_range = wr_addr < LIMIT;
    assign rd_in_range = s_axi.araddr < LIMIT;
    assign wr_idx      = wr_addr[2 +: IW];
    assign rd_idx      = s_axi.araddr[2 +: IW];

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        if (wr_state_q == WR_IDLE) begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi.awaddr;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi.wdata;
                wstrb_d  = s_axi.wstrb;
            end
            if (commit) begin
                wr_state_d = WR_RESP;
                bresp_d    = wr_in_range ? OKAY : ERR;
                for (int i = 0; i < NB; i++)
                    if (wr_in_range && wr_strb[i])
                        regs_d[wr_idx][8*i +: 8] = wr_data[8*i +: 8];
            end
        end else if (s_axi.bready) begin
            wr_state_d = WR_IDLE;
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
        end
        // Reads sample regs_q, so a same-edge commit is not yet visible.
        if (rd_state_q == RD_IDLE) begin
            if (ar_hs) begin
                rd_state_d = RD_DATA;
                rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
                rresp_d    = rd_in_range ? OKAY : ERR;
            end
        end else if (s_axi.rready) begin
            rd_state_d = RD_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end
endmodule
